// File: rtl/burst_req_arbiter_pkg.sv
// Shared definitions for the burst request arbiter: FSM encoding and default sizing.
package burst_req_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_DONE_PEND = 3'd3,
    S_RELEASE   = 3'd4
  } arb_state_t;

  localparam int DEF_NPORT   = 4;
  localparam int DEF_LSIZE   = 9;
  localparam int DEF_TIMEOUT = 4095;
  localparam int WDOG_W      = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to 0.
module rr_pick
  import burst_req_arbiter_pkg::*;
#(
  parameter int NPORT = DEF_NPORT
) (
  input  logic [NPORT-1:0]         req,
  input  logic [$clog2(NPORT)-1:0] ptr,
  output logic [$clog2(NPORT)-1:0] idx,
  output logic                     valid
);

  localparam int PW = $clog2(NPORT);

  logic [PW:0]   sum;
  logic [PW-1:0] cand;

  // Scan from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (PW + 1)'(k);
      if (sum >= (PW + 1)'(NPORT)) sum = sum - (PW + 1)'(NPORT);
      cand = sum[PW-1:0];
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/burst_req_arbiter.sv
// Round-robin arbiter letting NPORT FIFO status controllers share one burst engine,
// with a watchdog on the completion handshake. All outputs are registered.
module burst_req_arbiter
  import burst_req_arbiter_pkg::*;
#(
  parameter int NPORT   = DEF_NPORT,
  parameter int LSIZE   = DEF_LSIZE,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic [NPORT-1:0]         req_burst,
  input  logic [NPORT-1:0]         req_tail,
  input  logic [NPORT*LSIZE-1:0]   req_len,
  output logic [NPORT-1:0]         req_resp,
  output logic [NPORT-1:0]         req_done,
  output logic                     m_req,
  output logic                     m_tail,
  output logic [LSIZE-1:0]         m_len,
  output logic [$clog2(NPORT)-1:0] m_port,
  input  logic                     m_ack,
  input  logic                     m_done,
  output logic                     busy,
  output logic                     err_timeout,
  input  logic                     err_clr
);

  localparam int PW = $clog2(NPORT);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT);

  arb_state_t        state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     grant;
  logic [PW-1:0]     pick_idx;
  logic              pick_valid;
  logic [NPORT-1:0]  req_any;
  logic [WDOG_W-1:0] wdog;
  logic [WDOG_W-1:0] wdog_inc;
  logic [LSIZE-1:0]  len_arr [NPORT];

  assign req_any  = req_burst | req_tail;
  assign wdog_inc = wdog + WDOG_W'(1);
  assign m_port   = grant;

  always_comb begin
    for (int i = 0; i < NPORT; i++) len_arr[i] = req_len[i*LSIZE +: LSIZE];
  end

  rr_pick #(.NPORT(NPORT)) u_pick (
    .req   (req_any),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  function automatic logic [NPORT-1:0] port_bit(input logic [PW-1:0] p);
    logic [NPORT-1:0] b;
    b    = '0;
    b[p] = 1'b1;
    return b;
  endfunction

  // err_clr is applied first so a watchdog hit later in the same cycle overrides it.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      wdog        <= '0;
      m_req       <= 1'b0;
      m_tail      <= 1'b0;
      m_len       <= '0;
      req_resp    <= '0;
      req_done    <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      req_resp <= '0;
      req_done <= '0;
      if (err_clr) err_timeout <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (pick_valid) begin
            grant  <= pick_idx;
            m_len  <= len_arr[pick_idx];
            m_tail <= req_tail[pick_idx];
            m_req  <= 1'b1;
            busy   <= 1'b1;
            state  <= S_ISSUE;
          end
        end

        // An accepted request cannot be withdrawn, so m_ack outranks a dropped request.
        S_ISSUE: begin
          if (m_ack) begin
            req_resp <= port_bit(grant);
            m_req    <= 1'b0;
            wdog     <= '0;
            state    <= m_done ? S_DONE_PEND : S_WAIT_DONE;
          end else if (!req_any[grant]) begin
            m_req <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        S_WAIT_DONE: begin
          if (m_done) begin
            req_done <= port_bit(grant);
            state    <= S_RELEASE;
          end else if (wdog_inc == WDOG_LIMIT) begin
            wdog        <= wdog_inc;
            err_timeout <= 1'b1;
            req_done    <= port_bit(grant);
            state       <= S_RELEASE;
          end else begin
            wdog <= wdog_inc;
          end
        end

        S_DONE_PEND: begin
          req_done <= port_bit(grant);
          state    <= S_RELEASE;
        end

        S_RELEASE: begin
          rr_ptr <= (grant == PW'(NPORT - 1)) ? '0 : grant + PW'(1);
          busy   <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          m_req <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_req_arbiter.sv
// Scoreboard bench for burst_req_arbiter: directed grants are queued as expectations
// and a negedge monitor checks every grant, pulse and completion against them.
module tb_burst_req_arbiter;

  localparam int NPORT   = 4;
  localparam int LSIZE   = 9;
  localparam int TIMEOUT = 20;
  localparam int PW      = 2;

  logic                   clock = 1'b0;
  logic                   rst_n;
  logic [NPORT-1:0]       req_burst;
  logic [NPORT-1:0]       req_tail;
  logic [NPORT*LSIZE-1:0] req_len;
  logic [NPORT-1:0]       req_resp;
  logic [NPORT-1:0]       req_done;
  logic                   m_req;
  logic                   m_tail;
  logic [LSIZE-1:0]       m_len;
  logic [PW-1:0]          m_port;
  logic                   m_ack;
  logic                   m_done;
  logic                   busy;
  logic                   err_timeout;
  logic                   err_clr;

  always #5 clock = ~clock;

  burst_req_arbiter #(.NPORT(NPORT), .LSIZE(LSIZE), .TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .req_burst   (req_burst),
    .req_tail    (req_tail),
    .req_len     (req_len),
    .req_resp    (req_resp),
    .req_done    (req_done),
    .m_req       (m_req),
    .m_tail      (m_tail),
    .m_len       (m_len),
    .m_port      (m_port),
    .m_ack       (m_ack),
    .m_done      (m_done),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  typedef struct {
    int port;
    int len;
    int tail;
    int gap;
    int err;
    int aborted;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  int ack_delay  = 2;
  int done_delay = 10;
  int ack_cnt    = 0;
  int done_left  = 0;
  bit same_cycle = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic expectGrant(input int port, input int len, input int tail,
                             input int gap, input int err, input int aborted);
    exp_t e;
    e.port = port; e.len = len; e.tail = tail;
    e.gap = gap; e.err = err; e.aborted = aborted;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [NPORT-1:0] burst, input logic [NPORT-1:0] tail,
                               input int l0, input int l1, input int l2, input int l3);
    req_len   = {LSIZE'(l3), LSIZE'(l2), LSIZE'(l1), LSIZE'(l0)};
    req_burst = req_burst | burst;
    req_tail  = req_tail | tail;
  endtask

  // One cycle of requester and burst-engine behaviour, evaluated at the falling edge.
  task automatic tick();
    @(negedge clock);
    m_ack   = 1'b0;
    m_done  = 1'b0;
    err_clr = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (req_resp[i]) begin
        req_burst[i] = 1'b0;
        req_tail[i]  = 1'b0;
      end
    end
    if (done_left > 0) begin
      done_left--;
      if (done_left == 0) m_done = 1'b1;
    end
    if (m_req) begin
      ack_cnt++;
      if (ack_delay != 0 && ack_cnt == ack_delay) begin
        m_ack = 1'b1;
        if (same_cycle) m_done = 1'b1;
        else done_left = done_delay;
      end
    end else begin
      ack_cnt = 0;
    end
  endtask

  task automatic waitIdle(input int max_cycles);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (((req_burst | req_tail) != '0 || busy) && n < max_cycles);
    checkOutput("idle_reached", int'(((req_burst | req_tail) != '0) || busy), 0);
  endtask

  exp_t cur;
  bit   have_cur   = 1'b0;
  bit   prev_busy  = 1'b0;
  bit   prev_m_req = 1'b0;
  int   resp_cnt = 0, done_cnt = 0, resp_cyc = 0, done_cyc = 0, cyc = 0;

  initial forever begin
    @(negedge clock);
    cyc++;
    if (!rst_n) begin
      checkOutput("reset_outputs",
                  int'({m_req, m_tail, m_len, m_port, req_resp, req_done, busy, err_timeout}), 0);
      have_cur   = 1'b0;
      prev_busy  = 1'b0;
      prev_m_req = 1'b0;
    end else begin
      if (m_req && !prev_m_req) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_grant", int'(m_port), -1);
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
          resp_cnt = 0;
          done_cnt = 0;
          resp_cyc = 0;
          done_cyc = 0;
        end
      end
      if (m_req && have_cur) begin
        checkOutput("m_port", int'(m_port), cur.port);
        checkOutput("m_len", int'(m_len), cur.len);
        checkOutput("m_tail", int'(m_tail), cur.tail);
      end
      if (req_resp != '0) begin
        checkOutput("req_resp", int'(req_resp), (have_cur && cur.aborted == 0) ? (1 << cur.port) : 0);
        resp_cnt++;
        resp_cyc = cyc;
      end
      if (req_done != '0) begin
        checkOutput("req_done", int'(req_done), (have_cur && cur.aborted == 0) ? (1 << cur.port) : 0);
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_busy && !busy && have_cur) begin
        checkOutput("resp_count", resp_cnt, (cur.aborted != 0) ? 0 : 1);
        checkOutput("done_count", done_cnt, (cur.aborted != 0) ? 0 : 1);
        if (cur.aborted == 0) checkOutput("done_gap", done_cyc - resp_cyc, cur.gap);
        checkOutput("err_timeout", int'(err_timeout), cur.err);
        have_cur = 1'b0;
      end
      prev_busy  = busy;
      prev_m_req = m_req;
    end
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    req_burst = '0;
    req_tail  = '0;
    req_len   = '0;
    m_ack     = 1'b0;
    m_done    = 1'b0;
    err_clr   = 1'b0;
    repeat (3) tick();
    #1 rst_n = 1'b1;
    tick();

    // A stray m_done while idle must not produce any pulse.
    m_done = 1'b1;
    tick();
    tick();

    // All four ports request: strict round-robin from port 0.
    for (int p = 0; p < NPORT; p++) expectGrant(p, 200, 0, 10, 0, 0);
    applyStimulus(4'b1111, 4'b0000, 200, 200, 200, 200);
    waitIdle(400);

    expectGrant(0, 17, 0, 10, 0, 0);
    expectGrant(3, 300, 0, 10, 0, 0);
    applyStimulus(4'b1001, 4'b0000, 17, 0, 0, 300);
    waitIdle(200);

    // Tail beats burst on port 2; port 3 uses the maximum length.
    expectGrant(2, 37, 1, 10, 0, 0);
    expectGrant(3, 511, 0, 10, 0, 0);
    applyStimulus(4'b1100, 4'b0100, 0, 0, 37, 511);
    waitIdle(200);

    // m_ack and m_done together: done follows resp by one cycle.
    same_cycle = 1'b1;
    expectGrant(1, 1, 0, 1, 0, 0);
    applyStimulus(4'b0010, 4'b0000, 0, 1, 0, 0);
    waitIdle(100);
    same_cycle = 1'b0;

    // Engine never completes: watchdog fires TIMEOUT cycles after acceptance.
    done_delay = 0;
    expectGrant(3, 100, 0, TIMEOUT, 1, 0);
    applyStimulus(4'b1000, 4'b0000, 0, 0, 0, 100);
    waitIdle(100);
    done_delay = 10;
    err_clr = 1'b1;
    tick();
    expectGrant(0, 5, 0, 10, 0, 0);
    applyStimulus(4'b0001, 4'b0000, 5, 0, 0, 0);
    waitIdle(100);

    // Port 1 withdraws before acceptance; the pointer must stay on port 1.
    ack_delay = 0;
    expectGrant(1, 50, 0, 0, 0, 1);
    applyStimulus(4'b0010, 4'b0000, 0, 50, 0, 0);
    n = 0;
    while (!m_req && n < 20) begin tick(); n++; end
    checkOutput("abort_issue_seen", int'(m_req), 1);
    repeat (2) tick();
    req_burst[1] = 1'b0;
    waitIdle(50);
    ack_delay = 2;
    expectGrant(1, 60, 0, 10, 0, 0);
    expectGrant(2, 70, 0, 10, 0, 0);
    applyStimulus(4'b0110, 4'b0000, 0, 60, 70, 0);
    waitIdle(200);

    // Reset in WAIT_DONE of port 3; afterwards arbitration restarts at port 0.
    done_delay = 0;
    expectGrant(3, 80, 0, 0, 0, 0);
    applyStimulus(4'b1001, 4'b0000, 90, 0, 0, 80);
    n = 0;
    while (req_resp == '0 && n < 50) begin tick(); n++; end
    checkOutput("resp_before_reset", int'(req_resp), 8);
    repeat (3) tick();
    @(posedge clock);
    #2 rst_n = 1'b0;
    req_burst = '0;
    req_tail  = '0;
    done_left = 0;
    ack_cnt   = 0;
    tick();
    #1 rst_n = 1'b1;
    done_delay = 10;
    tick();
    for (int p = 0; p < NPORT; p++) expectGrant(p, 10 * (p + 1), 0, 10, 0, 0);
    applyStimulus(4'b1111, 4'b0000, 10, 20, 30, 40);
    waitIdle(400);

    repeat (3) tick();
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
